// File: rtl/pp_loop_sequencer.sv
// pp_loop_sequencer
//   Control FSM for one pipelined loop. It runs a fixed number of pre-loop cycles
//   and then issues iterations at a fixed initiation interval. It tracks in-flight
//   iterations through DEPTH stages, drains them, runs the post-loop cycles and
//   pulses done.
//
//   Ports
//     clock, reset           rising-edge clock, synchronous active-low reset
//     start, trip_count      loop request (taken in IDLE) and iteration count
//     stall, quit            freeze issue/stage advance; early exit with drain
//     busy                   FSM not idle
//     pre_states_valid       pre-loop cycle
//     iter_start_enable      iteration issued this cycle; iter_idx holds its index
//     stage_valid            per-stage occupancy, [0] is the issue itself
//     iter_end_enable        iteration retires this cycle
//     post_states_valid      one-hot post-loop step
//     quit_at_end            sticky flag: last run was ended by quit
//     done                   one-cycle completion pulse
//     cur_state              FSM encoding
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start
//   PRE   | pre-loop cycles
//   LOOP  | issuing iterations every II unstalled cycles
//   DRAIN | no issue; waiting for in-flight iterations to retire
//   POST  | post-loop cycles, one-hot walk on post_states_valid
//   DONE  | done pulse, back to IDLE
module pp_loop_sequencer #(
    parameter int TRIP_W      = 16,
    parameter int II          = 1,
    parameter int DEPTH       = 3,
    parameter int PRE_STATES  = 1,
    parameter int POST_STATES = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [TRIP_W-1:0]      trip_count,
    input  logic                   stall,
    input  logic                   quit,
    output logic                   busy,
    output logic                   pre_states_valid,
    output logic                   iter_start_enable,
    output logic [TRIP_W-1:0]      iter_idx,
    output logic [DEPTH-1:0]       stage_valid,
    output logic                   iter_end_enable,
    output logic [POST_STATES-1:0] post_states_valid,
    output logic                   quit_at_end,
    output logic                   done,
    output logic [2:0]             cur_state
);

    localparam int PW = (PRE_STATES > 1) ? $clog2(PRE_STATES) : 1;
    localparam int IW = (II > 1) ? $clog2(II) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRE_STATES - 1);
    localparam logic [IW-1:0]     II_LAST  = IW'(II - 1);
    localparam logic [TRIP_W:0]   CNT_ONE  = (TRIP_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_LOOP  = 3'd2,
        S_DRAIN = 3'd3,
        S_POST  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state, state_nxt;
    logic [TRIP_W-1:0]      trip_q;
    // One bit wider than trip so a full-range trip count never wraps.
    logic [TRIP_W:0]        issued, retired, retired_nxt;
    logic [PW-1:0]          pre_cnt;
    logic [IW-1:0]          ii_cnt;
    logic [POST_STATES-1:0] post_oh;
    logic                   issue, retire, last_issue;

    assign issue       = (state == S_LOOP) && (ii_cnt == '0) && !stall && !quit;
    assign last_issue  = issue && ((issued + CNT_ONE) == {1'b0, trip_q});
    assign retire      = iter_end_enable;
    assign retired_nxt = retired + {{TRIP_W{1'b0}}, retire};

    // Stage 0 is the issue itself; later stages are registers that hold on stall.
    generate
        if (DEPTH > 1) begin : g_stages
            logic [DEPTH-1:1] stage_q;
            always_ff @(posedge clock) begin
                if (!reset) begin
                    stage_q <= '0;
                end else if (!stall) begin
                    stage_q <= stage_valid[DEPTH-2:0];
                end
            end
            assign stage_valid = {stage_q, issue};
        end else begin : g_single
            assign stage_valid = issue;
        end
    endgenerate

    assign iter_end_enable = stage_valid[DEPTH-1] && !stall;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PRE;
            S_PRE:   if (pre_cnt == '0) state_nxt = (trip_q != '0) ? S_LOOP : S_POST;
            S_LOOP:  if (quit || last_issue) state_nxt = S_DRAIN;
            // Also covers the empty pipeline after an early quit.
            S_DRAIN: if (retired_nxt == issued) state_nxt = S_POST;
            S_POST:  if (post_oh[POST_STATES-1]) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            trip_q      <= '0;
            issued      <= '0;
            retired     <= '0;
            pre_cnt     <= '0;
            ii_cnt      <= '0;
            post_oh     <= '0;
            quit_at_end <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && start) begin
                trip_q      <= trip_count;
                quit_at_end <= 1'b0;
                issued      <= '0;
                retired     <= '0;
                pre_cnt     <= PRE_LAST;
                ii_cnt      <= '0;
            end

            if (state == S_PRE && pre_cnt != '0) begin
                pre_cnt <= pre_cnt - PW'(1);
            end

            if (state == S_LOOP) begin
                if (issue) begin
                    ii_cnt <= II_LAST;
                end else if (!stall && ii_cnt != '0) begin
                    ii_cnt <= ii_cnt - IW'(1);
                end
                if (quit) begin
                    quit_at_end <= 1'b1;
                end
            end

            if (issue) begin
                issued <= issued + CNT_ONE;
            end
            if (retire) begin
                retired <= retired_nxt;
            end

            if (state_nxt == S_POST && state != S_POST) begin
                post_oh <= POST_STATES'(1);
            end else if (state == S_POST) begin
                post_oh <= post_oh << 1;
            end else begin
                post_oh <= '0;
            end
        end
    end

    assign busy              = (state != S_IDLE);
    assign pre_states_valid  = (state == S_PRE);
    assign iter_start_enable = issue;
    assign iter_idx          = issue ? issued[TRIP_W-1:0] : '0;
    assign post_states_valid = (state == S_POST) ? post_oh : '0;
    assign done              = (state == S_DONE);
    assign cur_state         = state;

endmodule
